// File: rtl/usart_rx_fifo_bamse_pkg.sv
// Shared definitions for the Bamse USART receiver family.
// Holds the receive FSM state encodings, the status byte bit positions,
// the default port addresses and a helper that assembles the status byte.
// No ports; imported by usart_rx_fifo_bamse and usart_rx_fifo_bamse_fifo.
package usart_rx_fifo_bamse_pkg;

  // Receive FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Status byte bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_FERR      = 3;
  localparam int STAT_PERR      = 4;

  // Default port addresses on the CPU input-port bus
  localparam logic [7:0] DEF_ADDR      = 8'h0a;
  localparam logic [7:0] DEF_STAT_ADDR = 8'h0b;

  // Assemble the status byte; the upper three bits always read as zero
  function automatic logic [7:0] packStatus(input logic notEmpty, input logic full,
                                            input logic ovr, input logic ferr,
                                            input logic perr);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_NOT_EMPTY] = notEmpty;
    s[STAT_FULL]      = full;
    s[STAT_OVR]       = ovr;
    s[STAT_FERR]      = ferr;
    s[STAT_PERR]      = perr;
    return s;
  endfunction

endpackage

// File: rtl/usart_rx_fifo_bamse_fifo.sv
// Synchronous receive FIFO for the Bamse USART receiver.
// Ports:
//   clk, rst   system clock, synchronous active-high reset (flushes the FIFO)
//   push_i     write data_i this cycle (ignored when full unless popping too)
//   pop_i      remove the head entry this cycle (ignored when empty)
//   data_i     byte to store
//   data_o     current head entry (undefined content when empty)
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
//   count_o    number of stored entries, width clog2(DEPTH)+1
module usart_rx_fifo_bamse_fifo
  import usart_rx_fifo_bamse_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rdPtr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Storage has no reset; emptiness is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usart_rx_fifo_bamse.sv
// Bamse USART receiver with receive FIFO, status port and level interrupt.
// Deserialises 8N1 serial (8E1/8O1 when USART_RX_PARITY_EN is defined) into
// a DEPTH-entry FIFO readable on the CPU input-port bus.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx           asynchronous serial input, idle high
//   clk_per_bit  clocks per bit period (>= 8), latched at each start edge
//   parity_odd   0 = even, 1 = odd parity (only with USART_RX_PARITY_EN)
//   address      port address from the CPU
//   ren          one-clock read strobe
//   port_out     combinational read data (FIFO head or status byte)
//   int_rx       registered interrupt, set while count >= INT_LEVEL
// Configuration macro: USART_RX_PARITY_EN adds the parity bit and perr flag.
module usart_rx_fifo_bamse
  import usart_rx_fifo_bamse_pkg::*;
#(
  parameter logic [7:0] ADDR      = DEF_ADDR,
  parameter logic [7:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter int         DEPTH     = 8,
  parameter int         INT_LEVEL = 1,
  parameter int         CPB_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [CPB_W-1:0] clk_per_bit,
  input  logic             parity_odd,
  input  logic [7:0]       address,
  input  logic             ren,
  output logic [7:0]       port_out,
  output logic             int_rx
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] INT_LVL = CW'(INT_LEVEL);

  logic rxMeta_q, rxSync_q, rxPrev_q, armed_q;
  logic [2:0]       state_q, state_d;
  logic [CPB_W-1:0] cpb_q, cpb_d, tick_q, tick_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, setFerr, setPerr;
  logic             ovr_q, ferr_q, perr_q, intRx_q;
  logic [7:0]       head;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic             dataSel, statSel, popReq, clrFlags, ovrSet;

`ifdef USART_RX_PARITY_EN
  logic parityBad_q, parityBad_d;
`else
  logic unusedParity;
  assign unusedParity = parity_odd;
`endif

  // Two-flop synchroniser plus a delayed copy for edge detection. The
  // receiver stays disarmed after reset until the line has been seen idle,
  // so a line held low through reset cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b0;
      rxSync_q <= 1'b0;
      rxPrev_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
      if (rxSync_q) armed_q <= 1'b1;
    end
  end

  // Frame FSM: START samples half a bit in to reject glitches, then every
  // later sample is one full bit period after the previous one.
  always_comb begin
    state_d  = state_q;
    cpb_d    = cpb_q;
    tick_d   = tick_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    setFerr  = 1'b0;
    setPerr  = 1'b0;
`ifdef USART_RX_PARITY_EN
    parityBad_d = parityBad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (armed_q && rxPrev_q && !rxSync_q) begin
          state_d = ST_START;
          cpb_d   = clk_per_bit;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (tick_q == (cpb_q >> 1) - CPB_W'(1)) begin
          tick_d   = '0;
          bitCnt_d = '0;
          state_d  = rxSync_q ? ST_IDLE : ST_DATA;
        end else begin
          tick_d = tick_q + CPB_W'(1);
        end
      end
      ST_DATA: begin
        if (tick_q == cpb_q - CPB_W'(1)) begin
          tick_d   = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
`ifdef USART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          tick_d = tick_q + CPB_W'(1);
        end
      end
`ifdef USART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q == cpb_q - CPB_W'(1)) begin
          tick_d      = '0;
          parityBad_d = ((^shift_q) ^ rxSync_q) != parity_odd;
          state_d     = ST_STOP;
        end else begin
          tick_d = tick_q + CPB_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (tick_q == cpb_q - CPB_W'(1)) begin
          tick_d = '0;
          if (rxSync_q) begin
            push    = 1'b1;
`ifdef USART_RX_PARITY_EN
            setPerr = parityBad_q;
`endif
            state_d = ST_IDLE;
          end else begin
            setFerr = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          tick_d = tick_q + CPB_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxSync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cpb_q    <= '0;
      tick_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
`ifdef USART_RX_PARITY_EN
      parityBad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cpb_q    <= cpb_d;
      tick_q   <= tick_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
`ifdef USART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
`endif
    end
  end

  assign dataSel  = (address == ADDR);
  assign statSel  = (address == STAT_ADDR);
  assign popReq   = ren && dataSel;
  assign clrFlags = ren && statSel;
  assign ovrSet   = push && full && !popReq;

  usart_rx_fifo_bamse_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (popReq),
    .data_i  (shift_q),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Sticky error flags: a status read clears them, but an error arriving in
  // the same cycle as the clear takes priority and stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      intRx_q <= 1'b0;
    end else begin
      ovr_q   <= (ovr_q  && !clrFlags) || ovrSet;
      ferr_q  <= (ferr_q && !clrFlags) || setFerr;
      perr_q  <= (perr_q && !clrFlags) || setPerr;
      intRx_q <= (count >= INT_LVL);
    end
  end

  assign int_rx = intRx_q;

  // Read mux; the data port reads zero rather than stale storage when empty
  always_comb begin
    port_out = 8'h00;
    if (dataSel) begin
      port_out = empty ? 8'h00 : head;
    end else if (statSel) begin
      port_out = packStatus(!empty, full, ovr_q, ferr_q, perr_q);
    end
  end

endmodule
